// File: rtl/flappy_pkg.sv
// flappy_pkg: state encoding, physics mode and default game constants for the bird controller.
package flappy_pkg;
  typedef enum logic [4:0] {
    ST_I       = 5'b00001,
    ST_GRAV    = 5'b00010,
    ST_FLAP    = 5'b00100,
    ST_UNPRESS = 5'b01000,
    ST_LOST    = 5'b10000
  } state_e;
  typedef enum logic {PH_GRAV = 1'b0, PH_FLAP = 1'b1} phys_mode_e;
  localparam int DEF_Y_W      = 10;
  localparam int DEF_VEL_W    = 6;
  localparam int DEF_SCORE_W  = 8;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_FLAP_VEL = 8;
  localparam int DEF_VMAX     = 10;
  localparam int DEF_Y_MIN    = 0;
  localparam int DEF_Y_MAX    = 460;
  localparam int DEF_Y_START  = 240;
  localparam int DEF_X_START  = 160;
endpackage

// File: rtl/bird_physics_step.sv
// bird_physics_step: one frame of bird motion (gravity or flap impulse) with
// velocity clamp, floor detect and ceiling clamp, computed in widened signed math.
module bird_physics_step
  import flappy_pkg::*;
#(
  parameter int Y_W      = DEF_Y_W,
  parameter int VEL_W    = DEF_VEL_W,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int VMAX     = DEF_VMAX,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX
) (
  input  logic [Y_W-1:0]   y,
  input  logic [VEL_W-1:0] vel,
  input  phys_mode_e       mode,
  output logic [Y_W-1:0]   y_n,
  output logic [VEL_W-1:0] v_n,
  output logic             floor_hit
);
  localparam logic signed [VEL_W:0] V_G    = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0] V_MAX  = (VEL_W+1)'(VMAX);
  localparam logic signed [VEL_W:0] V_FLAP = (VEL_W+1)'(FLAP_VEL);
  localparam logic signed [Y_W+1:0] YS_MAX = (Y_W+2)'(Y_MAX);
  localparam logic signed [Y_W+1:0] YS_MIN = (Y_W+2)'(Y_MIN);
  logic signed [VEL_W:0] v_sum, v_new;
  logic signed [Y_W+1:0] y_new;
  logic                  ceil_hit;
  // Semi-implicit Euler: position advances by the already-updated velocity.
  always_comb begin
    v_sum     = $signed({vel[VEL_W-1], vel}) + V_G;
    v_new     = (mode == PH_FLAP) ? -V_FLAP : ((v_sum > V_MAX) ? V_MAX : v_sum);
    y_new     = $signed({2'b00, y}) + (Y_W+2)'(v_new);
    floor_hit = y_new >= YS_MAX;
    ceil_hit  = y_new <= YS_MIN;
    y_n       = floor_hit ? Y_W'(Y_MAX) : (ceil_hit ? Y_W'(Y_MIN) : y_new[Y_W-1:0]);
    v_n       = (ceil_hit && !floor_hit) ? '0 : v_new[VEL_W-1:0];
  end
endmodule

// File: rtl/flappy_bird_ctrl.sv
// flappy_bird_ctrl: one-hot game FSM, per-frame bird motion registers and
// saturating score, with Start/Ack handshake for begin and restart.
module flappy_bird_ctrl
  import flappy_pkg::*;
#(
  parameter int Y_W      = DEF_Y_W,
  parameter int VEL_W    = DEF_VEL_W,
  parameter int SCORE_W  = DEF_SCORE_W,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int VMAX     = DEF_VMAX,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int Y_START  = DEF_Y_START,
  parameter int X_START  = DEF_X_START
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Tick,
  input  logic               Start,
  input  logic               Ack,
  input  logic               Flap_Button,
  input  logic               Hit,
  input  logic               Pipe_Pass,
  output logic [Y_W-1:0]     YBird,
  output logic [Y_W-1:0]     XBird,
  output logic [VEL_W-1:0]   Vel,
  output logic [SCORE_W-1:0] Score,
  output logic               q_I,
  output logic               q_Grav,
  output logic               q_Flap,
  output logic               q_UnPress,
  output logic               q_Lost
);
  state_e             state_q, state_d;
  logic [Y_W-1:0]     y_q, y_d, y_step;
  logic [VEL_W-1:0]   vel_q, vel_d, v_step;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic               floor_hit;
  phys_mode_e         mode;

  assign mode      = (state_q == ST_FLAP) ? PH_FLAP : PH_GRAV;
  assign score_inc = (Pipe_Pass && score_q != {SCORE_W{1'b1}}) ? score_q + 1'b1 : score_q;

  bird_physics_step #(
    .Y_W(Y_W), .VEL_W(VEL_W), .GRAVITY(GRAVITY), .FLAP_VEL(FLAP_VEL),
    .VMAX(VMAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) u_step (
    .y(y_q), .vel(vel_q), .mode(mode),
    .y_n(y_step), .v_n(v_step), .floor_hit(floor_hit)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    score_d = score_q;
    case (state_q)
      ST_I: begin
        state_d = Start ? ST_GRAV : ST_I;
        score_d = Start ? '0 : score_q;
      end
      ST_GRAV: begin
        score_d = score_inc;
        if (Hit) state_d = ST_LOST;
        else if (Tick && floor_hit) begin
          state_d = ST_LOST;
          y_d     = y_step;
          vel_d   = v_step;
        end else if (Flap_Button) state_d = ST_FLAP;
        else if (Tick) begin
          y_d   = y_step;
          vel_d = v_step;
        end
      end
      ST_FLAP: begin
        score_d = score_inc;
        if (Hit) state_d = ST_LOST;
        else if (Tick) begin
          state_d = ST_UNPRESS;
          y_d     = y_step;
          vel_d   = v_step;
        end
      end
      ST_UNPRESS: begin
        score_d = score_inc;
        if (Hit) state_d = ST_LOST;
        else begin
          y_d     = Tick ? y_step : y_q;
          vel_d   = Tick ? v_step : vel_q;
          state_d = (Tick && floor_hit) ? ST_LOST : (Flap_Button ? ST_UNPRESS : ST_GRAV);
        end
      end
      ST_LOST: state_d = Ack ? ST_I : ST_LOST;
      default: state_d = ST_I;
    endcase
    // Idle position is (re)loaded on the same edge that enters I.
    if (state_d == ST_I) begin
      y_d   = Y_W'(Y_START);
      vel_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_I;
      y_q     <= Y_W'(Y_START);
      vel_q   <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      score_q <= score_d;
    end
  end

  assign YBird     = y_q;
  assign XBird     = Y_W'(X_START);
  assign Vel       = vel_q;
  assign Score     = score_q;
  assign q_I       = state_q[0];
  assign q_Grav    = state_q[1];
  assign q_Flap    = state_q[2];
  assign q_UnPress = state_q[3];
  assign q_Lost    = state_q[4];
endmodule

// File: tb/tb_flappy_bird_ctrl.sv
// tb_flappy_bird_ctrl: vector table, multi-cycle corner sequences and random
// stimulus against an integer game model for flappy_bird_ctrl.
module tb_flappy_bird_ctrl;
  localparam int S_I = 0, S_GRAV = 1, S_FLAP = 2, S_UNP = 3, S_LOST = 4;
  localparam logic [5:0] TK = 6'b100000, ST = 6'b010000, AK = 6'b001000;
  localparam logic [5:0] FL = 6'b000100, HT = 6'b000010, PP = 6'b000001, NONE = 6'b000000;

  logic Clk = 1'b0, Reset_n = 1'b0;
  logic Tick = 1'b0, Start = 1'b0, Ack = 1'b0, Flap_Button = 1'b0, Hit = 1'b0, Pipe_Pass = 1'b0;
  logic [9:0] YBird, XBird;
  logic [5:0] Vel;
  logic [7:0] Score;
  logic q_I, q_Grav, q_Flap, q_UnPress, q_Lost;

  int n_chk = 0, n_fail = 0;
  int m_st, m_y, m_v, m_sc;

  typedef struct {
    logic [5:0] inp;
    int es, ey, ev, esc;
  } vec_t;
  vec_t tbl[18];

  always #5 Clk = ~Clk;

  flappy_bird_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick), .Start(Start), .Ack(Ack),
    .Flap_Button(Flap_Button), .Hit(Hit), .Pipe_Pass(Pipe_Pass),
    .YBird(YBird), .XBird(XBird), .Vel(Vel), .Score(Score),
    .q_I(q_I), .q_Grav(q_Grav), .q_Flap(q_Flap), .q_UnPress(q_UnPress), .q_Lost(q_Lost)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int es, input int ey, input int ev, input int esc);
    chk({tag, ".state"}, int'({q_Lost, q_UnPress, q_Flap, q_Grav, q_I}), 1 << es);
    chk({tag, ".y"}, int'(YBird), ey);
    chk({tag, ".vel"}, int'($signed(Vel)), ev);
    chk({tag, ".score"}, int'(Score), esc);
  endtask

  task automatic model_reset();
    m_st = S_I; m_y = 240; m_v = 0; m_sc = 0;
  endtask

  // Game rules with plain integers: Hit beats floor beats button beats motion.
  task automatic model_step(input logic [5:0] in);
    bit tk = in[5], stt = in[4], ak = in[3], fl = in[2], ht = in[1], pp = in[0];
    int nv, ny;
    if (m_st == S_I) begin
      if (stt) begin m_st = S_GRAV; m_sc = 0; end
    end else if (m_st == S_LOST) begin
      if (ak) m_st = S_I;
    end else begin
      if (pp && m_sc < 255) m_sc++;
      nv = (m_st == S_FLAP) ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
      ny = m_y + nv;
      if (ny <= 0) begin ny = 0; nv = 0; end
      if (ht) m_st = S_LOST;
      else if (m_st == S_FLAP) begin
        if (tk) begin m_y = ny; m_v = nv; m_st = S_UNP; end
      end else if (tk && ny >= 460) begin
        m_y = 460; m_v = nv; m_st = S_LOST;
      end else if (m_st == S_GRAV && fl) m_st = S_FLAP;
      else begin
        if (tk) begin m_y = ny; m_v = nv; end
        if (m_st == S_UNP && !fl) m_st = S_GRAV;
      end
    end
    if (m_st == S_I) begin m_y = 240; m_v = 0; end
  endtask

  task automatic step(input logic [5:0] in);
    @(negedge Clk);
    {Tick, Start, Ack, Flap_Button, Hit, Pipe_Pass} = in;
    @(posedge Clk);
    model_step(in);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    {Tick, Start, Ack, Flap_Button, Hit, Pipe_Pass} = NONE;
    repeat (2) @(negedge Clk);
    model_reset();
    chk_all("reset", S_I, 240, 0, 0);
    Reset_n = 1'b1;
  endtask

  initial begin
    int n;
    bit fl_lvl;
    logic [5:0] rin;
    tbl = '{
      '{ST,            S_GRAV, 240,  0, 0},
      '{TK,            S_GRAV, 241,  1, 0},
      '{TK,            S_GRAV, 243,  2, 0},
      '{TK,            S_GRAV, 246,  3, 0},
      '{FL,            S_FLAP, 246,  3, 0},
      '{FL | PP,       S_FLAP, 246,  3, 1},
      '{FL | TK,       S_UNP,  238, -8, 1},
      '{FL | TK,       S_UNP,  231, -7, 1},
      '{FL,            S_UNP,  231, -7, 1},
      '{NONE,          S_GRAV, 231, -7, 1},
      '{TK,            S_GRAV, 225, -6, 1},
      '{HT | FL | TK | PP, S_LOST, 225, -6, 2},
      '{ST,            S_LOST, 225, -6, 2},
      '{TK | PP | FL,  S_LOST, 225, -6, 2},
      '{AK,            S_I,    240,  0, 2},
      '{PP | TK,       S_I,    240,  0, 2},
      '{ST,            S_GRAV, 240,  0, 0},
      '{TK | HT,       S_LOST, 240,  0, 0}
    };
    do_reset();
    chk("xbird", int'(XBird), 160);
    foreach (tbl[i]) begin
      step(tbl[i].inp);
      chk_all($sformatf("vec%0d", i), tbl[i].es, tbl[i].ey, tbl[i].ev, tbl[i].esc);
    end

    // Held button: a single impulse, then gravity until release.
    do_reset();
    step(ST);
    repeat (3) step(TK);
    step(FL);
    for (int k = 1; k <= 20; k++) begin
      step(FL | TK);
      if (k == 1) chk_all("flap1", S_UNP, 238, -8, 0);
    end
    chk_all("held20", S_UNP, 275, 10, 0);
    step(NONE);
    chk_all("release", S_GRAV, 275, 10, 0);

    // Climb to Y=4, then one more flap hits the ceiling.
    do_reset();
    step(ST);
    repeat (8) step(TK);
    chk_all("fall8", S_GRAV, 276, 8, 0);
    repeat (34) begin step(FL); step(FL | TK); step(NONE); end
    chk_all("y4", S_GRAV, 4, -8, 0);
    step(FL);
    step(FL | TK);
    chk_all("ceiling", S_UNP, 0, 0, 0);
    step(NONE);
    chk_all("ceil_release", S_GRAV, 0, 0, 0);

    // Free fall to the floor, scoring on the way, then Ack and restart.
    n = 0;
    while (!q_Lost && n < 100) begin
      step(TK | (n < 3 ? PP : NONE));
      n++;
    end
    chk("floor_reached", int'(q_Lost), 1);
    chk_all("floor", S_LOST, 460, 10, 3);
    step(AK);
    chk_all("ack", S_I, 240, 0, 3);
    step(ST);
    chk_all("restart", S_GRAV, 240, 0, 0);

    repeat (300) step(PP);
    chk_all("saturate", S_GRAV, 240, 0, 255);
    step(HT | FL | TK);
    chk_all("hit_tick", S_LOST, 240, 0, 255);

    // Asynchronous reset between clock edges while in UNPRESS.
    do_reset();
    step(ST);
    step(FL);
    step(FL | TK);
    chk_all("unpress", S_UNP, 232, -8, 0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst", S_I, 240, 0, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(ST);
    chk_all("post_rst", S_GRAV, 240, 0, 0);

    fl_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) fl_lvl = ~fl_lvl;
      rin = {$urandom_range(2) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
             fl_lvl, $urandom_range(79) == 0, $urandom_range(5) == 0};
      step(rin);
      chk_all($sformatf("rnd%0d", i), m_st, m_y, m_v, m_sc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
